// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin APB master sharing one bus among NREQ requesters.
// An ACCESS-phase timeout aborts silent slaves so the bus cannot hang.
module apb_req_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_write,
  input  logic [32*NREQ-1:0]   req_addr,
  input  logic [32*NREQ-1:0]   req_wdata,
  input  logic [4*NREQ-1:0]    req_strb,
  output logic [NREQ-1:0]      req_done,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [31:0]          PADDR,
  output logic [31:0]          PWDATA,
  output logic [3:0]           PSTRB,
  input  logic                 PREADY,
  input  logic [31:0]          PRDATA
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_last;
  logic [IW-1:0]   r_gnt;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_done;
  logic [31:0]     r_rdata;
  logic            r_err;
  logic            r_psel;
  logic            r_penable;
  logic            r_pwrite;
  logic [31:0]     r_paddr;
  logic [31:0]     r_pwdata;
  logic [3:0]      r_pstrb;

  logic [NREQ-1:0] w_elig;
  logic            w_any;
  logic [IW-1:0]   w_gnt;
  logic            w_take;
  int              w_dist;
  int              w_best;
  logic [31:0]     w_addr;
  logic [31:0]     w_wdata;
  logic [3:0]      w_strb;
  logic            w_write;

  // Round-robin pick: eligible requester at the smallest distance past the last grant.
  always_comb begin
    w_elig = req_valid & ~r_done;
    w_any  = |w_elig;
    w_gnt  = r_last;
    w_best = NREQ;
    w_dist = 0;
    w_take = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      w_dist = (i + NREQ - 1 - int'(r_last)) % NREQ;
      w_take = w_elig[i] && (w_dist < w_best);
      w_best = w_take ? w_dist : w_best;
      w_gnt  = w_take ? IW'(i) : w_gnt;
    end
  end

  // Request field mux for the winning requester.
  always_comb begin
    w_addr  = 32'd0;
    w_wdata = 32'd0;
    w_strb  = 4'd0;
    w_write = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      w_addr  = (w_gnt == IW'(i)) ? req_addr[32*i +: 32]  : w_addr;
      w_wdata = (w_gnt == IW'(i)) ? req_wdata[32*i +: 32] : w_wdata;
      w_strb  = (w_gnt == IW'(i)) ? req_strb[4*i +: 4]    : w_strb;
      w_write = (w_gnt == IW'(i)) ? req_write[i]          : w_write;
    end
  end

  // Transfer sequencer: arbitration, APB phases, timeout abort and response pulse.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state   <= ST_IDLE;
      r_last    <= IW'(NREQ - 1);
      r_gnt     <= '0;
      r_cnt     <= '0;
      r_done    <= '0;
      r_rdata   <= 32'd0;
      r_err     <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= 32'd0;
      r_pwdata  <= 32'd0;
      r_pstrb   <= 4'd0;
    end else begin
      r_done  <= '0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt     <= w_gnt;
            r_last    <= w_gnt;
            r_paddr   <= w_addr;
            r_pwdata  <= w_wdata;
            r_pwrite  <= w_write;
            r_pstrb   <= w_write ? w_strb : 4'd0;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_state   <= ST_SETUP;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_done    <= {{(NREQ-1){1'b0}}, 1'b1} << r_gnt;
            r_rdata   <= r_pwrite ? 32'd0 : PRDATA;
            r_state   <= ST_IDLE;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            // Silent slave: abort and report the error to the owner.
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_done    <= {{(NREQ-1){1'b0}}, 1'b1} << r_gnt;
            r_err     <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_done  = r_done;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign PSTRB     = r_pstrb;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Randomized bench for apb_req_arbiter: requesters and slave are driven at random and
// every output is compared each cycle against a transaction-level model.
module tb_apb_req_arbiter;

  localparam int NREQ    = 3;
  localparam int TIMEOUT = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_write;
  logic [32*NREQ-1:0]  req_addr;
  logic [32*NREQ-1:0]  req_wdata;
  logic [4*NREQ-1:0]   req_strb;
  logic [NREQ-1:0]     req_done;
  logic [31:0]         rsp_rdata;
  logic                rsp_err;
  logic                PSEL, PENABLE, PWRITE;
  logic [31:0]         PADDR, PWDATA;
  logic [3:0]          PSTRB;
  logic                PREADY;
  logic [31:0]         PRDATA;

  apb_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(clk), .PRESETn(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb),
    .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA)
  );

  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // requester side of the model
  logic [31:0]     m_addr [NREQ];
  logic [31:0]     m_wdata[NREQ];
  logic [3:0]      m_strb [NREQ];
  logic            m_write[NREQ];
  bit              m_pend [NREQ];
  logic [NREQ-1:0] m_vin;
  // transfer in flight: owner, cycle index (0 = SETUP), planned wait states
  int              m_last, m_g, m_t, m_wait;
  bit              m_busy;
  int              mode;
  bit              rst_done;

  logic            e_psel, e_pen, e_write, e_err;
  logic [31:0]     e_addr, e_wdata, e_rdata;
  logic [3:0]      e_strb;
  logic [NREQ-1:0] e_done;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("psel",      PSEL,      e_psel);
    check_val("penable",   PENABLE,   e_pen);
    check_val("pwrite",    PWRITE,    e_write);
    check_val("paddr",     PADDR,     e_addr);
    check_val("pwdata",    PWDATA,    e_wdata);
    check_val("pstrb",     PSTRB,     e_strb);
    check_val("req_done",  req_done,  e_done);
    check_val("rsp_err",   rsp_err,   e_err);
    check_val("rsp_rdata", rsp_rdata, e_rdata);
  endtask

  task automatic new_req(input int i);
    m_pend[i]  = 1'b1;
    m_vin[i]   = 1'b1;
    m_addr[i]  = $urandom;
    m_wdata[i] = $urandom;
    m_strb[i]  = 4'($urandom_range(0, 15));
    m_write[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      req_addr[32*i +: 32]  = m_addr[i];
      req_wdata[32*i +: 32] = m_wdata[i];
      req_strb[4*i +: 4]    = m_strb[i];
      req_write[i]          = m_write[i];
    end
    req_valid = m_vin;
  endtask

  // Everything the bus side forgets on reset; pending requests survive.
  task automatic model_reset();
    m_last  = NREQ - 1;
    m_busy  = 1'b0;
    m_t     = 0;
    e_psel  = 1'b0; e_pen   = 1'b0; e_write = 1'b0; e_err = 1'b0;
    e_addr  = 32'd0; e_wdata = 32'd0; e_rdata = 32'd0;
    e_strb  = 4'd0; e_done  = '0;
    for (int i = 0; i < NREQ; i++)
      if (m_pend[i] && !m_vin[i]) m_pend[i] = 1'b0;
  endtask

  // Drive this cycle's inputs, then predict the outputs of the next cycle.
  task automatic one_cycle();
    logic [NREQ-1:0] cur_done;
    bit   elig[NREQ];
    int   pct_new, pct_keep, g, idx, r;
    cur_done = e_done;
    pct_new  = (mode == 1) ? 100 : 25;
    pct_keep = (mode == 1) ? 100 : 30;
    for (int i = 0; i < NREQ; i++) begin
      if (m_pend[i] && cur_done[i]) begin
        m_pend[i] = 1'b0;
        m_vin[i]  = 1'b0;
        if (int'($urandom_range(0, 99)) < pct_keep) new_req(i);
      end else if (!m_pend[i]) begin
        if (int'($urandom_range(0, 99)) < pct_new) new_req(i);
      end else if (m_busy && m_g == i && m_vin[i] && mode == 0 && int'($urandom_range(0, 99)) < 15) begin
        m_vin[i] = 1'b0;
      end
    end
    PRDATA = $urandom;
    if (m_busy && m_t >= 1) PREADY = ((m_t - 1) == m_wait);
    else PREADY = 1'($urandom_range(0, 1));
    drive_reqs();

    e_done  = '0;
    e_err   = 1'b0;
    e_rdata = 32'd0;
    if (!m_busy) begin
      for (int i = 0; i < NREQ; i++) elig[i] = m_vin[i] && !cur_done[i];
      g = -1;
      for (int k = 1; k <= NREQ; k++) begin
        idx = (m_last + k) % NREQ;
        if (g < 0 && elig[idx]) g = idx;
      end
      if (g >= 0) begin
        m_g = g; m_last = g; m_busy = 1'b1; m_t = 0;
        r = int'($urandom_range(0, 9));
        if (r < 2) m_wait = TIMEOUT + 3;
        else if (r == 2) m_wait = TIMEOUT - 1;
        else m_wait = int'($urandom_range(0, 3));
        e_psel  = 1'b1;
        e_pen   = 1'b0;
        e_addr  = m_addr[g];
        e_wdata = m_wdata[g];
        e_write = m_write[g];
        e_strb  = m_write[g] ? m_strb[g] : 4'd0;
      end else begin
        e_psel = 1'b0;
        e_pen  = 1'b0;
      end
    end else if (m_t == 0) begin
      e_pen = 1'b1;
      m_t   = 1;
    end else if (PREADY) begin
      e_psel = 1'b0; e_pen = 1'b0; m_busy = 1'b0;
      e_done[m_g] = 1'b1;
      e_rdata = e_write ? 32'd0 : PRDATA;
    end else if (m_t - 1 == TIMEOUT - 1) begin
      e_psel = 1'b0; e_pen = 1'b0; m_busy = 1'b0;
      e_done[m_g] = 1'b1;
      e_err = 1'b1;
    end else begin
      m_t++;
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; mode = 0; rst_done = 1'b0;
    rst_n = 1'b0; PREADY = 1'b0; PRDATA = 32'd0;
    m_vin = '0; m_g = 0; m_wait = 0;
    for (int i = 0; i < NREQ; i++) begin
      m_pend[i] = 1'b0; m_addr[i] = 32'd0; m_wdata[i] = 32'd0;
      m_strb[i] = 4'd0; m_write[i] = 1'b0;
    end
    drive_reqs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    for (int c = 0; c < 1500; c++) begin
      mode = (c >= 700 && c < 1100) ? 1 : 0;
      if (!rst_done && c >= 900 && m_busy && m_t >= 2) begin
        PREADY = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("rst_psel",     PSEL,     1'b0);
        check_val("rst_penable",  PENABLE,  1'b0);
        check_val("rst_req_done", req_done, '0);
        check_val("rst_paddr",    PADDR,    32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
        rst_done = 1'b1;
      end else begin
        one_cycle();
        @(posedge clk);
        #1;
        check_outputs();
      end
    end
    if (!rst_done) check_val("reset_in_access_reached", 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
